// File: rtl/mrisc_alu_pkg.sv
// ---------------------------------------------------------------------------
// mrisc_alu_pkg
//   Shared definitions for the miniRISC ALU and the logic that feeds it:
//   default datapath widths, the ALU-sharing sequencer state encoding,
//   ALU command constants (ALUsel + ALUop pairs) and a small helper that
//   turns a one-hot two-port grant into a port index.
// ---------------------------------------------------------------------------
package mrisc_alu_pkg;

    localparam int ALU_DATA_W = 32;   // operand / result width
    localparam int ALU_OP_W   = 5;    // ALUop width

    // Sequencer states for the shared-ALU controller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // One ALU command is the {ALUsel, ALUop} pair seen by the ALU.
    typedef struct packed {
        logic                sel;
        logic [ALU_OP_W-1:0] op;
    } alu_cmd_t;

    localparam alu_cmd_t ALU_ADD = '{sel: 1'b0, op: 5'd1};
    localparam alu_cmd_t ALU_SUB = '{sel: 1'b0, op: 5'd2};
    localparam alu_cmd_t ALU_AND = '{sel: 1'b0, op: 5'd3};
    localparam alu_cmd_t ALU_OR  = '{sel: 1'b0, op: 5'd4};
    localparam alu_cmd_t ALU_XOR = '{sel: 1'b0, op: 5'd5};
    localparam alu_cmd_t ALU_SLL = '{sel: 1'b1, op: 5'd1};
    localparam alu_cmd_t ALU_SRL = '{sel: 1'b1, op: 5'd2};

    // Index of the granted port for a grant vector with at most one bit set.
    // Port 1 is the only non-zero index, so bit 1 is the index itself.
    function automatic logic grant_index(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin grant, purely combinational. The caller owns the
//   last_grant register and updates it only when a grant is actually taken.
//
//   Ports:
//     req_valid  [1:0] in   per-port request valid
//     last_grant       in   index of the port granted most recently
//     grant      [1:0] out  one-hot grant (or 2'b00 when nobody requests)
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie: the port that did not win last time goes first.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
//   Shares the single combinational miniRISC ALU between the execute stage
//   (port 0) and the branch/address unit (port 1). A request is accepted on
//   a valid/ready handshake in IDLE, its operands are registered onto the
//   ALU inputs, the ALU result and flags are captured one cycle later, and
//   the captured response is held until the consumer takes it. Grants
//   alternate round-robin when both ports request at once.
//
//   Ports:
//     clk, rst                      clock, async active-high reset
//     req_valid/req_ready [1:0]     per-port request handshake
//     req_a, req_b  [2*DATA_W-1:0]  operands, port i at [i*DATA_W +: DATA_W]
//     req_sel       [1:0]           ALUsel per port
//     req_op        [2*OP_W-1:0]    ALUop per port, same packing as req_a
//     alu_a/alu_b/alu_sel/alu_op    registered command to the shared ALU
//     alu_result, alu_carry/zero/sign  combinational ALU outputs
//     resp_valid/resp_ready         response handshake
//     resp_id                       port that issued the response
//     resp_result, resp_carry/zero/sign  captured ALU outputs
//     busy                          high whenever an operation is in flight
// ---------------------------------------------------------------------------
module alu_share_ctrl
    import mrisc_alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    input  logic [1:0]            req_sel,
    input  logic [2*OP_W-1:0]     req_op,

    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic                  alu_sel,
    output logic [OP_W-1:0]       alu_op,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_carry,
    input  logic                  alu_zero,
    input  logic                  alu_sign,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [DATA_W-1:0]     resp_result,
    output logic                  resp_carry,
    output logic                  resp_zero,
    output logic                  resp_sign,

    output logic                  busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q,       state_d;
    logic                last_grant_q,  last_grant_d;
    logic                id_q,          id_d;

    logic [DATA_W-1:0]   alu_a_q,       alu_a_d;
    logic [DATA_W-1:0]   alu_b_q,       alu_b_d;
    logic                alu_sel_q,     alu_sel_d;
    logic [OP_W-1:0]     alu_op_q,      alu_op_d;

    logic [DATA_W-1:0]   resp_result_q, resp_result_d;
    logic                resp_carry_q,  resp_carry_d;
    logic                resp_zero_q,   resp_zero_d;
    logic                resp_sign_q,   resp_sign_d;

    logic [1:0]          grant;
    logic                acc_port;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    rr_arb2 u_arb (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign acc_port = grant_index(grant);

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every *_d and every output gets a default before the case,
        // so no path through this block can infer a latch.
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_sel_d     = alu_sel_q;
        alu_op_d      = alu_op_q;
        resp_result_d = resp_result_q;
        resp_carry_d  = resp_carry_q;
        resp_zero_d   = resp_zero_q;
        resp_sign_d   = resp_sign_q;
        req_ready     = 2'b00;

        case (state_q)
            IDLE: begin
                // The flops are already forced to their reset values while
                // rst is high; gating here keeps req_ready quiet as well.
                req_ready = rst ? 2'b00 : grant;
                if (grant != 2'b00) begin
                    alu_a_d      = acc_port ? req_a[DATA_W +: DATA_W] : req_a[0 +: DATA_W];
                    alu_b_d      = acc_port ? req_b[DATA_W +: DATA_W] : req_b[0 +: DATA_W];
                    alu_sel_d    = acc_port ? req_sel[1]              : req_sel[0];
                    alu_op_d     = acc_port ? req_op[OP_W +: OP_W]    : req_op[0 +: OP_W];
                    id_d         = acc_port;
                    last_grant_d = acc_port;
                    state_d      = EXEC;
                end
            end

            EXEC: begin
                // ALU inputs have been stable for a full cycle: capture.
                resp_result_d = alu_result;
                resp_carry_d  = alu_carry;
                resp_zero_d   = alu_zero;
                resp_sign_d   = alu_sign;
                state_d       = RESP;
            end

            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register here, including the operand and response
            // stages, has a defined reset value so the ALU and the consumer
            // never see X after reset.
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            id_q          <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_sel_q     <= 1'b0;
            alu_op_q      <= '0;
            resp_result_q <= '0;
            resp_carry_q  <= 1'b0;
            resp_zero_q   <= 1'b0;
            resp_sign_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            id_q          <= id_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_sel_q     <= alu_sel_d;
            alu_op_q      <= alu_op_d;
            resp_result_q <= resp_result_d;
            resp_carry_q  <= resp_carry_d;
            resp_zero_q   <= resp_zero_d;
            resp_sign_q   <= resp_sign_d;
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign alu_op      = alu_op_q;

    assign resp_valid  = (state_q == RESP);
    assign resp_id     = id_q;
    assign resp_result = resp_result_q;
    assign resp_carry  = resp_carry_q;
    assign resp_zero   = resp_zero_q;
    assign resp_sign   = resp_sign_q;

    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
//   Bench for alu_share_ctrl together with a behavioural stand-in for the
//   miniRISC ALU. Directed scenarios first, then a randomized run against a
//   transaction-level model of the sharing rules.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;
    import mrisc_alu_pkg::*;

    localparam int DW = 32;
    localparam int OW = 5;

    typedef struct packed {
        logic [DW-1:0] r;
        logic          c;
        logic          z;
        logic          s;
    } res_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_a = '0;
    logic [2*DW-1:0] req_b = '0;
    logic [1:0]      req_sel = 2'b00;
    logic [2*OW-1:0] req_op = '0;
    logic [DW-1:0]   alu_a, alu_b, alu_result;
    logic            alu_sel;
    logic [OW-1:0]   alu_op;
    logic            alu_carry, alu_zero, alu_sign;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic            resp_id;
    logic [DW-1:0]   resp_result;
    logic            resp_carry, resp_zero, resp_sign;
    logic            busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: what the datapath ALU does with a command.
    function automatic res_t alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     input logic sel, input logic [OW-1:0] op);
        res_t        o;
        logic [DW:0] w;
        o = '0;
        w = '0;
        case ({sel, op})
            ALU_ADD: begin w = {1'b0, a} + {1'b0, b}; o.r = w[DW-1:0]; o.c = w[DW]; end
            ALU_SUB: begin o.r = a - b; o.c = (a < b); end
            ALU_AND: o.r = a & b;
            ALU_OR:  o.r = a | b;
            ALU_XOR: o.r = a ^ b;
            ALU_SLL: o.r = a << b[4:0];
            ALU_SRL: o.r = a >> b[4:0];
            default: o.r = a;
        endcase
        o.z = (o.r == '0);
        o.s = o.r[DW-1];
        return o;
    endfunction

    res_t alu_o;
    always_comb alu_o = alu_ref(alu_a, alu_b, alu_sel, alu_op);
    assign alu_result = alu_o.r;
    assign alu_carry  = alu_o.c;
    assign alu_zero   = alu_o.z;
    assign alu_sign   = alu_o.s;

    alu_share_ctrl #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_sel     (req_sel),
        .req_op      (req_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .alu_sign    (alu_sign),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_carry  (resp_carry),
        .resp_zero   (resp_zero),
        .resp_sign   (resp_sign),
        .busy        (busy)
    );

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic sel, input logic [OW-1:0] op);
        req_a[p*DW +: DW] = a;
        req_b[p*DW +: DW] = b;
        req_sel[p]        = sel;
        req_op[p*OW +: OW] = op;
    endtask

    // Present one request on port p alone, accept it, and stop in the
    // response cycle (resp_ready left high so the caller's tick completes it).
    task automatic issue(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic sel, input logic [OW-1:0] op);
        set_port(p, a, b, sel, op);
        req_valid  = (p == 1) ? 2'b10 : 2'b01;
        resp_ready = 1'b1;
        tick();
        req_valid = 2'b00;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        set_port(0, 32'h11, 32'h22, 1'b0, 5'd1);
        set_port(1, 32'h33, 32'h44, 1'b0, 5'd1);
        req_valid = 2'b11;
        #2;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready);
        end
        checks++;
        if ({busy, resp_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_valid: got %b expected 00", {busy, resp_valid});
        end
        checks++;
        if ({alu_a, alu_b, alu_sel, alu_op} !== '0) begin
            errors++; $display("FAIL reset_alu_regs: got %h/%h/%b/%h expected all 0", alu_a, alu_b, alu_sel, alu_op);
        end
        checks++;
        if ({resp_result, resp_carry, resp_zero, resp_sign, resp_id} !== '0) begin
            errors++; $display("FAIL reset_resp_regs: got %h c%b z%b s%b id%b expected all 0",
                               resp_result, resp_carry, resp_zero, resp_sign, resp_id);
        end
        tick();
        tick();
        checks++;
        if ({req_ready, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_held: got ready=%b busy=%b expected 00/0", req_ready, busy);
        end
        req_valid = 2'b00;
        rst = 1'b0;
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_add();
        set_port(0, 32'd8, 32'd9, ALU_ADD.sel, ALU_ADD.op);
        req_valid  = 2'b01;
        resp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL add_grant: got %b expected 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        #1;
        checks++;
        if ({busy, resp_valid, req_ready} !== 4'b1000) begin
            errors++; $display("FAIL add_exec_status: got busy/valid/ready=%b expected 1000", {busy, resp_valid, req_ready});
        end
        checks++;
        if ({alu_a, alu_b, alu_sel, alu_op} !== {32'd8, 32'd9, 1'b0, 5'd1}) begin
            errors++; $display("FAIL add_alu_cmd: got %0d/%0d/%b/%0d expected 8/9/0/1", alu_a, alu_b, alu_sel, alu_op);
        end
        tick();
        checks++;
        if ({resp_valid, resp_id, resp_result, resp_carry, resp_zero, resp_sign} !== {1'b1, 1'b0, 32'd17, 3'b000}) begin
            errors++; $display("FAIL add_resp: got v%b id%b %0d c%b z%b s%b expected v1 id0 17 c0 z0 s0",
                               resp_valid, resp_id, resp_result, resp_carry, resp_zero, resp_sign);
        end
        tick();
        checks++;
        if ({busy, resp_valid} !== 2'b00) begin
            errors++; $display("FAIL add_done: got busy/valid=%b expected 00", {busy, resp_valid});
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_simultaneous();
        logic [DW-1:0] exp_res [2];
        logic [DW-1:0] exp_a   [2];
        logic [1:0]    exp_g;
        int            p;
        exp_res[0] = 32'd97;  exp_a[0] = 32'd100;
        exp_res[1] = 32'd10;  exp_a[1] = 32'd5;
        rst = 1'b1;
        set_port(0, 32'd100, 32'd3, ALU_SUB.sel, ALU_SUB.op);
        set_port(1, 32'd5,   32'd5, ALU_ADD.sel, ALU_ADD.op);
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            p = k % 2;
            exp_g = (p == 1) ? 2'b10 : 2'b01;
            checks++;
            if (req_ready !== exp_g) begin
                errors++; $display("FAIL tie_grant[%0d]: got %b expected %b", k, req_ready, exp_g);
            end
            tick();
            checks++;
            if (alu_a !== exp_a[p]) begin
                errors++; $display("FAIL tie_alu_a[%0d]: got %0d expected %0d", k, alu_a, exp_a[p]);
            end
            tick();
            checks++;
            if ({resp_valid, resp_id, resp_result} !== {1'b1, p[0], exp_res[p]}) begin
                errors++; $display("FAIL tie_resp[%0d]: got v%b id%b %0d expected v1 id%0d %0d",
                                   k, resp_valid, resp_id, resp_result, p, exp_res[p]);
            end
            tick();
        end
        req_valid = 2'b00;
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        set_port(1, 32'h0000_1234, 32'h0000_00F0, ALU_AND.sel, ALU_AND.op);
        req_valid  = 2'b10;
        resp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL bp_grant: got %b expected 10", req_ready);
        end
        tick();
        req_valid = 2'b00;
        tick();
        set_port(0, 32'd7, 32'd1, ALU_SUB.sel, ALU_SUB.op);
        req_valid = 2'b01;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({resp_valid, busy, req_ready} !== 4'b1100) begin
                errors++; $display("FAIL bp_status[%0d]: got valid/busy/ready=%b expected 1100", k, {resp_valid, busy, req_ready});
            end
            checks++;
            if ({resp_id, resp_result, resp_carry, resp_zero, resp_sign} !== {1'b1, 32'h30, 3'b000}) begin
                errors++; $display("FAIL bp_hold[%0d]: got id%b %h c%b z%b s%b expected id1 00000030 c0 z0 s0",
                                   k, resp_id, resp_result, resp_carry, resp_zero, resp_sign);
            end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release_valid: got %b expected 1", resp_valid);
        end
        tick();
        checks++;
        if ({resp_valid, busy, req_ready} !== 4'b0001) begin
            errors++; $display("FAIL bp_after: got valid/busy/ready=%b expected 0001", {resp_valid, busy, req_ready});
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (alu_a !== 32'd7) begin
            errors++; $display("FAIL bp_waiter_alu_a: got %0d expected 7", alu_a);
        end
        tick();
        checks++;
        if ({resp_valid, resp_id, resp_result} !== {1'b1, 1'b0, 32'd6}) begin
            errors++; $display("FAIL bp_waiter_resp: got v%b id%b %0d expected v1 id0 6", resp_valid, resp_id, resp_result);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_flags();
        issue(0, 32'hFFFF_FFFF, 32'd1, ALU_ADD.sel, ALU_ADD.op);
        checks++;
        if ({resp_result, resp_carry, resp_zero, resp_sign} !== {32'h0, 3'b110}) begin
            errors++; $display("FAIL flag_add_wrap: got %h c%b z%b s%b expected 00000000 c1 z1 s0",
                               resp_result, resp_carry, resp_zero, resp_sign);
        end
        tick();
        issue(1, 32'd1, 32'd2, ALU_SUB.sel, ALU_SUB.op);
        checks++;
        if ({resp_id, resp_result, resp_carry, resp_zero, resp_sign} !== {1'b1, 32'hFFFF_FFFF, 3'b101}) begin
            errors++; $display("FAIL flag_sub_neg: got id%b %h c%b z%b s%b expected id1 ffffffff c1 z0 s1",
                               resp_id, resp_result, resp_carry, resp_zero, resp_sign);
        end
        tick();
        issue(0, 32'h8000_0001, 32'd4, ALU_SLL.sel, ALU_SLL.op);
        checks++;
        if ({resp_result, resp_sign} !== {32'h0000_0010, 1'b0}) begin
            errors++; $display("FAIL flag_sll: got %h s%b expected 00000010 s0", resp_result, resp_sign);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_exec();
        // Port 0 alone wins, so without a reset the next tie would go to port 1.
        set_port(0, 32'd3, 32'd4, ALU_ADD.sel, ALU_ADD.op);
        set_port(1, 32'd9, 32'd9, ALU_XOR.sel, ALU_XOR.op);
        req_valid  = 2'b01;
        resp_ready = 1'b1;
        tick();
        req_valid = 2'b11;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({resp_valid, busy, req_ready} !== 4'b0000) begin
            errors++; $display("FAIL rst_exec_status: got valid/busy/ready=%b expected 0000", {resp_valid, busy, req_ready});
        end
        checks++;
        if (alu_a !== '0) begin
            errors++; $display("FAIL rst_exec_alu_a: got %0d expected 0", alu_a);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL rst_exec_tie: got %b expected 01", req_ready);
        end
        req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({resp_valid, busy} !== 2'b00) begin
                errors++; $display("FAIL rst_exec_no_resp[%0d]: got valid/busy=%b expected 00", k, {resp_valid, busy});
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Randomized traffic against a transaction-level model: each port holds
    // a pending request until it is taken; the shared unit serves one
    // request at a time, answers one cycle after taking it, and holds the
    // answer until the consumer accepts it.
    task automatic test_random(input int cycles);
        bit            pend [2];
        logic [DW-1:0] pa [2];
        logic [DW-1:0] pb [2];
        logic          psel [2];
        logic [OW-1:0] pop [2];
        bit            m_busy;
        int            m_age;
        int            m_last;
        int            win;
        res_t          m_exp;
        logic          m_id;
        logic [DW+DW+1+OW-1:0] m_cmd;
        logic [1:0]    exp_g;

        rst = 1'b1;
        req_valid = 2'b00;
        #1;
        rst = 1'b0;
        pend[0] = 0; pend[1] = 0;
        m_busy = 0; m_age = 0; m_last = 1; m_id = 0; m_exp = '0; m_cmd = '0;

        for (int cyc = 0; cyc < cycles; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pa[p]   = $urandom;
                    case ($urandom_range(0, 2))
                        0:       pb[p] = $urandom;
                        1:       pb[p] = $urandom_range(0, 40);
                        default: pb[p] = pa[p];
                    endcase
                    psel[p] = ($urandom_range(0, 1) == 1);
                    pop[p]  = OW'($urandom_range(0, 6));
                    pend[p] = 1;
                    set_port(p, pa[p], pb[p], psel[p], pop[p]);
                end
            end
            req_valid  = {pend[1], pend[0]};
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;

            win = -1;
            if (!m_busy) begin
                if (pend[0] && pend[1]) win = (m_last == 1) ? 0 : 1;
                else if (pend[0])       win = 0;
                else if (pend[1])       win = 1;
            end
            exp_g = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;

            checks++;
            if ({req_ready, busy} !== {exp_g, m_busy}) begin
                errors++; $display("FAIL rnd_ready_busy @%0d: got ready=%b busy=%b expected %b/%b",
                                   cyc, req_ready, busy, exp_g, m_busy);
            end
            checks++;
            if (resp_valid !== (m_busy && m_age >= 1)) begin
                errors++; $display("FAIL rnd_resp_valid @%0d: got %b expected %b", cyc, resp_valid, (m_busy && m_age >= 1));
            end
            if (m_busy && m_age == 0) begin
                checks++;
                if ({alu_a, alu_b, alu_sel, alu_op} !== m_cmd) begin
                    errors++; $display("FAIL rnd_alu_cmd @%0d: got %h/%h/%b/%h expected %h",
                                       cyc, alu_a, alu_b, alu_sel, alu_op, m_cmd);
                end
            end
            if (m_busy && m_age >= 1) begin
                checks++;
                if ({resp_id, resp_result, resp_carry, resp_zero, resp_sign} !== {m_id, m_exp}) begin
                    errors++; $display("FAIL rnd_resp @%0d: got id%b %h c%b z%b s%b expected id%b %h c%b z%b s%b",
                                       cyc, resp_id, resp_result, resp_carry, resp_zero, resp_sign,
                                       m_id, m_exp.r, m_exp.c, m_exp.z, m_exp.s);
                end
            end

            // Effect of the coming edge on the model.
            if (win >= 0) begin
                m_busy  = 1;
                m_age   = 0;
                m_id    = win[0];
                m_last  = win;
                m_exp   = alu_ref(pa[win], pb[win], psel[win], pop[win]);
                m_cmd   = {pa[win], pb[win], psel[win], pop[win]};
                pend[win] = 0;
            end else if (m_busy) begin
                if (m_age >= 1 && resp_ready) m_busy = 0;
                else                          m_age++;
            end
            tick();
        end
        req_valid = 2'b00;
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_add();
        test_simultaneous();
        test_backpressure();
        test_flags();
        test_reset_mid_exec();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, expected the run to end earlier", $time);
        $fatal(1);
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and two-way arbiter that shares the single combinational ALU of the miniRISC datapath between two requesters: port 0 is the execute stage and port 1 is the branch/address unit. Each request is accepted on a valid/ready handshake and registered into the ALU operand stage. The result and flags (carry, zero, sign) are captured one cycle later and returned on a tagged response channel with backpressure. Grants alternate round-robin, so neither requester starves.

## Interface
Parameters:
- DATA_W, 32, operand/result width (matches ALU a/b/result)
- OP_W, 5, ALU opcode width (matches ALUop)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  2  per-port request valid; bit i = port i
- req_ready  out  2  per-port accept; request i taken on edge where req_valid[i] & req_ready[i]
- req_a  in  2*DATA_W  operand a; port i at [i*DATA_W +: DATA_W]
- req_b  in  2*DATA_W  operand b, same packing
- req_sel  in  2  ALUsel per port
- req_op  in  2*OP_W  ALUop per port, packed as req_a
- alu_a, alu_b  out  DATA_W  registered operands driven to the shared ALU
- alu_sel  out  1  registered ALUsel to ALU
- alu_op  out  OP_W  registered ALUop to ALU
- alu_result  in  DATA_W  ALU result (combinational from alu_*)
- alu_carry, alu_zero, alu_sign  in  1  ALU flags
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  port that issued the response
- resp_result  out  DATA_W  captured result
- resp_carry, resp_zero, resp_sign  out  1  captured flags
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready = grant vector (at most one bit set); all other states drive req_ready = 2'b00.
  - On accept, latch that port's a, b, sel and op into alu_* and its index into the id register, update last_grant, then go to EXEC.
- EXEC: exactly one cycle. At the end of the cycle, capture alu_result and the three flags into resp_* and go to RESP.
- RESP:
  - resp_valid = 1. resp_* are held stable until resp_ready is high on a clock edge, then go to IDLE.
- Arbitration:
  - Only one port valid: grant that port.
  - Both valid: grant the port != last_grant.
  - last_grant resets to 1, so port 0 wins the first tie.
- Requester rule: once req_valid[i] is asserted it holds its operands stable until accepted. The block does not check this.
- ALU semantics are opaque to this block. No width conversion: results and flags pass through bit-exact.
- Reset values:
  - state = IDLE, last_grant = 1, resp_id = 0.
  - req_ready = 0 while rst is asserted; the first grant is possible in the first cycle after release.
  - alu_a = alu_b = 0, alu_sel = 0, alu_op = 0.
  - resp_valid = 0, resp_result = 0, resp_carry = resp_zero = resp_sign = 0, busy = 0.

## Timing
- Request accepted at edge N → alu_* valid after N. Result captured at N+1, and resp_valid is high from N+1 until the handshake edge.
- Minimum occupancy is 3 cycles per operation (IDLE accept, EXEC, RESP with resp_ready=1). Peak throughput is 1 op / 3 cycles.
- resp_ready held low: stay in RESP indefinitely, with no new accepts. Both requesters see req_ready = 0.
- Response handshake edge: next state is IDLE, and a new accept is possible in the following cycle.
- Request arriving while busy: waits. After IDLE is re-entered, round-robin considers only the ports valid in that cycle.
- Async rst mid-EXEC or mid-RESP: the in-flight operation is discarded and no response is issued. All registers go to their reset values immediately, without waiting for clk.

## Structure
- Shared package mrisc_alu_pkg:
  - DATA_W and OP_W defaults.
  - State encoding typedef: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - ALU op constants, including ALU_ADD (ALUsel=0, ALUop=5'd1).
- One sub-module, rr_arb2: 2-input round-robin grant, combinational from req_valid and last_grant. Its last_grant register stays in the parent.
- The existing ALU module is instantiated outside this block, alongside it in the datapath. The bench instantiates both.

## Test plan
- Single ADD, port 0: a=8, b=9, sel=0, op=1, resp_ready=1 → req_ready[0] one cycle; resp_valid 2 cycles after accept; resp_id=0, resp_result=17, zero=0, carry=0, sign=0.
- Simultaneous: both ports valid at the first cycle after reset (port1 a=5, b=5) → port 0 served first, port 1 next. Each response is tagged with the correct id, and grants alternate over 4 consecutive ties (0,1,0,1).
- Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_* stable, req_ready=00, busy=1; on release, one handshake then IDLE.
- Flag capture: ADD with a=32'hFFFFFFFF, b=1 → resp_result=0, resp_zero=1, resp_carry=1.
- Reset mid-EXEC: assert rst for 1 ns between edges → resp_valid, busy and req_ready drop immediately; no response after release; next tie goes to port 0.
